// File: rtl/booth_accumulator.sv
// rtl/booth_accumulator.sv - frame accumulator for signed 8-bit multiplier products
//
// Purpose: sums acc_len signed products (0 means 16) into a signed ACC_WIDTH
// accumulator. Each product is captured on a rising edge of product_ready.
// The completed sum is held with sum_valid until sum_ack.
// Optional build macro: BOOTH_ACC_SAT_EN. When it is defined, an overflowing add
// saturates to the most positive or most negative value. When it is undefined,
// an overflowing add wraps. The overflow flag is set in both builds.
//
// Ports:
//   clock          rising-edge clock
//   reset_n        asynchronous active-low reset
//   product[7:0]   signed product, valid while product_ready is high
//   product_ready  ready level; its rising edge is a capture event
//   acc_len[3:0]   products per frame, latched at the first capture (0 = 16)
//   clear          synchronous frame abort, highest priority
//   sum_ack        consumer accepts the held sum
//   sum            accumulator value (all states)
//   sum_valid      frame complete, sum held
//   busy           frame in progress
//   overflow       sticky overflow flag for the current frame
//   overrun        one-cycle pulse when a product is dropped while a sum is held
module booth_accumulator #(
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [7:0]           product,
    input  logic                 product_ready,
    input  logic [3:0]           acc_len,
    input  logic                 clear,
    input  logic                 sum_ack,
    output logic [ACC_WIDTH-1:0] sum,
    output logic                 sum_valid,
    output logic                 busy,
    output logic                 overflow,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    state_t                 state_q, state_d;
    logic                   rdy_q;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [4:0]             len_q, len_d;
    logic                   overflow_q, overflow_d;
    logic                   overrun_q, overrun_d;

    logic                   capture;
    logic                   start;
    logic [4:0]             new_len;
    logic [ACC_WIDTH-1:0]   prod_ext;
    logic [ACC_WIDTH-1:0]   add_raw;
    logic                   add_ovf;
    logic [ACC_WIDTH-1:0]   add_res;

    // A held-high ready produces exactly one capture.
    assign capture  = product_ready & ~rdy_q;
    assign new_len  = (acc_len == 4'd0) ? 5'd16 : {1'b0, acc_len};
    assign prod_ext = {{(ACC_WIDTH-8){product[7]}}, product};
    assign add_raw  = acc_q + prod_ext;
    // Signed overflow: both operands share a sign and the result sign differs.
    assign add_ovf  = (acc_q[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                      (add_raw[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);

`ifdef BOOTH_ACC_SAT_EN
    assign add_res  = add_ovf ? (acc_q[ACC_WIDTH-1] ? ACC_MIN : ACC_MAX) : add_raw;
`else
    assign add_res  = add_raw;
`endif

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        overflow_d = overflow_q;
        overrun_d  = 1'b0;
        start      = 1'b0;

        if (clear) begin
            state_d    = IDLE;
            acc_d      = '0;
            cnt_d      = 5'd0;
            overflow_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    start = capture;
                end
                ACCUM: begin
                    if (capture) begin
                        acc_d      = add_res;
                        cnt_d      = cnt_q + 5'd1;
                        overflow_d = overflow_q | add_ovf;
                        if (cnt_q + 5'd1 == len_q) begin
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    if (sum_ack) begin
                        // An ack with a capture in the same cycle starts the next frame.
                        state_d = IDLE;
                        start   = capture;
                    end else if (capture) begin
                        overrun_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase

            if (start) begin
                acc_d      = prod_ext;
                cnt_d      = 5'd1;
                len_d      = new_len;
                overflow_d = 1'b0;
                state_d    = (new_len == 5'd1) ? DONE : ACCUM;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rdy_q      <= 1'b1;
            acc_q      <= '0;
            cnt_q      <= 5'd0;
            len_q      <= 5'd0;
            overflow_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rdy_q      <= product_ready;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            overflow_q <= overflow_d;
            overrun_q  <= overrun_d;
        end
    end

    assign sum       = acc_q;
    assign sum_valid = (state_q == DONE);
    assign busy      = (state_q == ACCUM);
    assign overflow  = overflow_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/booth_accumulator.md
BOOTH_ACCUMULATOR -- requirements
Module: booth_accumulator

Interface
REQ-001 SHALL have parameter ACC_WIDTH, default 16, signed accumulator width in bits (legal range 8..32).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port product  input  8  signed two's-complement product from the upstream multiplier.
REQ-005 SHALL have port product_ready  input  1  multiplier ready level; a product is valid when this is high.
REQ-006 SHALL have port acc_len  input  4  products per frame; 0 means 16.
REQ-007 SHALL have port clear  input  1  synchronous frame abort.
REQ-008 SHALL have port sum_ack  input  1  consumer accepts sum.
REQ-009 SHALL have port sum  output  ACC_WIDTH  signed accumulated result.
REQ-010 SHALL have port sum_valid  output  1  sum is complete and held.
REQ-011 SHALL have port busy  output  1  frame in progress (ACCUM state).
REQ-012 SHALL have port overflow  output  1  sticky arithmetic-overflow flag for the current frame.
REQ-013 SHALL have port overrun  output  1  one-cycle pulse when a product is dropped.

Function
REQ-014 SHALL register product_ready into rdy_q; a capture event SHALL be product_ready=1 and rdy_q=0, so a held-high ready counts exactly once.
REQ-015 SHALL sign-extend product to ACC_WIDTH before every add.
REQ-016 SHALL implement states IDLE, ACCUM and DONE.
REQ-017 IDLE + capture: acc=sext(product), cnt=1, latch acc_len; next state SHALL be DONE if latched length is 1, else ACCUM.
REQ-018 ACCUM + capture: acc=acc+sext(product), cnt=cnt+1; next state SHALL be DONE when cnt+1 equals the latched length.
REQ-019 DONE: sum_valid=1 and sum held stable until sum_ack=1, then the block SHALL return to IDLE.
REQ-020 Latency: sum_valid SHALL rise on the clock edge following the cycle in which the final capture event is seen.
REQ-021 A capture in DONE without sum_ack SHALL be dropped, pulse overrun for one cycle, and leave sum unchanged.
REQ-022 A capture in DONE with sum_ack in the same cycle SHALL start a new frame per REQ-017 (no drop, no overrun).
REQ-023 acc_len changes after the first capture of a frame SHALL have no effect on that frame.
REQ-024 overflow SHALL set when a signed add overflows ACC_WIDTH, and SHALL clear on the first capture of the next frame.
REQ-025 clear=1 SHALL force IDLE, acc=0, cnt=0, sum_valid=0 and overflow=0, with priority over capture and sum_ack in the same cycle.
REQ-026 sum SHALL equal acc in all states.
REQ-027 busy SHALL be 1 only in ACCUM.

Reset
REQ-028 reset_n=0 SHALL immediately force IDLE, acc=0, cnt=0, sum=0, sum_valid=0, busy=0, overflow=0 and overrun=0, including mid-frame.
REQ-029 rdy_q SHALL reset to 1, so a ready level present at reset release is not counted as a product.

Configuration
REQ-030 With BOOTH_ACC_SAT_EN defined, an overflowing add SHALL clamp acc to the most positive or most negative ACC_WIDTH value and set overflow.
REQ-031 Without BOOTH_ACC_SAT_EN, an overflowing add SHALL wrap modulo 2^ACC_WIDTH and set overflow.

Verification
REQ-032 acc_len=2, products 3 then 0xFD (-3) -> sum=0x0000, sum_valid rises one edge after the 2nd ready rise and holds until sum_ack.
REQ-033 acc_len=4, product 0x07 four times, ready held high 3 cycles each time -> sum=0x001C, exactly 4 captures counted, busy high from 1st capture to 4th.
REQ-034 ACC_WIDTH=8, acc_len=2, products 100 and 100 -> macro off: sum=0xC8, overflow=1; macro on: sum=0x7F, overflow=1.
REQ-035 In DONE with sum=0x0005: ready rise without ack -> overrun pulses, sum stays 0x0005; ready rise (product 2) with sum_ack -> new frame, acc=0x0002, no overrun.
REQ-036 acc_len=4, reset_n pulled low asynchronously after 2 captures -> all outputs 0 before the next edge; ready held high at release -> no capture.
REQ-037 clear and capture in the same cycle mid-frame -> IDLE, sum=0, capture ignored.
